// File: rtl/mul_rr_arbiter.sv
// mul_rr_arbiter
// Round-robin front end that shares one pipelined signed multiplier among
// NUM_REQ requesters. One operand pair is accepted per cycle and registered
// onto mul_a/mul_b. A tag pipe follows each operation through the multiplier
// latency so that its product comes back on rsp_valid/rsp_data to the
// requester that issued it.
//
// Optional feature: define MUL_RR_ARBITER_PERF_EN to add the perf_cnt output,
// one saturating 16-bit accept counter per requester.
module mul_rr_arbiter #(
  parameter int MUL_SIZE = 32,
  parameter int NUM_REQ  = 4,
  parameter int MUL_LAT  = 2
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic [NUM_REQ-1:0]          req_valid,
  input  logic [NUM_REQ*MUL_SIZE-1:0] req_a,
  input  logic [NUM_REQ*MUL_SIZE-1:0] req_b,
  output logic [NUM_REQ-1:0]          req_ready,
  output logic [MUL_SIZE-1:0]         mul_a,
  output logic [MUL_SIZE-1:0]         mul_b,
  input  logic [2*MUL_SIZE-1:0]       mul_c,
  output logic [NUM_REQ-1:0]          rsp_valid,
  output logic [2*MUL_SIZE-1:0]       rsp_data,
  output logic                        busy
`ifdef MUL_RR_ARBITER_PERF_EN
  ,
  output logic [NUM_REQ*16-1:0]       perf_cnt
`endif
);

  // Requester IDs and the tag pipe depth (issue stage plus multiplier stages).
  localparam int ID_W  = $clog2(NUM_REQ);
  localparam int DEPTH = 1 + MUL_LAT;

  // NUM_REQ in one bit more than an ID, so modulo sums never overflow.
  localparam logic [ID_W:0] NUM_REQ_W = (ID_W+1)'(NUM_REQ);

  // Adds an offset to a requester ID and wraps it back into 0..NUM_REQ-1.
  // Both operands are below NUM_REQ, so one conditional subtract suffices.
  function automatic logic [ID_W-1:0] wrap_add(input logic [ID_W-1:0] base,
                                               input logic [ID_W:0]   off);
    logic [ID_W:0] sum;
    sum = {1'b0, base} + off;
    if (sum >= NUM_REQ_W) begin
      sum = sum - NUM_REQ_W;
    end
    return sum[ID_W-1:0];
  endfunction

  // Round-robin pointer: the requester searched first in the current cycle.
  logic [ID_W-1:0] ptr_q, ptr_d;

  // Arbitration results.
  logic [ID_W-1:0]    winner;
  logic [ID_W-1:0]    cand;
  logic               any_valid;
  logic               accept;
  logic [NUM_REQ-1:0] grant;

  // Registered operands towards the multiplier.
  logic [MUL_SIZE-1:0] mul_a_q, mul_a_d;
  logic [MUL_SIZE-1:0] mul_b_q, mul_b_d;

  // Tag pipe: stage 0 holds the operation just issued; the last stage lines
  // up with its product arriving on mul_c.
  logic [DEPTH-1:0]           tag_valid_q, tag_valid_d;
  logic [DEPTH-1:0][ID_W-1:0] tag_id_q, tag_id_d;

  // Registered response to the requesters.
  logic [NUM_REQ-1:0]    rsp_valid_q, rsp_valid_d;
  logic [2*MUL_SIZE-1:0] rsp_data_q, rsp_data_d;

  // Search from ptr upward with wrap-around; the first valid requester wins.
  always_comb begin
    any_valid = 1'b0;
    winner    = ptr_q;
    cand      = ptr_q;
    for (int i = 0; i < NUM_REQ; i++) begin
      cand = wrap_add(ptr_q, (ID_W+1)'(i));
      if (!any_valid && req_valid[cand]) begin
        any_valid = 1'b1;
        winner    = cand;
      end
    end
  end

  // One-hot grant, forced to zero while reset is held so nothing is accepted.
  always_comb begin
    grant  = '0;
    accept = any_valid & ~reset;
    if (accept) begin
      grant[winner] = 1'b1;
    end
  end

  assign req_ready = grant;

  // On accept, the pointer moves just past the winner; otherwise it holds.
  always_comb begin
    ptr_d = ptr_q;
    if (accept) begin
      ptr_d = wrap_add(winner, (ID_W+1)'(1));
    end
  end

  // Capture the winner's operands; idle cycles leave the last pair in place
  // because their products are discarded by the tag pipe anyway.
  always_comb begin
    mul_a_d = mul_a_q;
    mul_b_d = mul_b_q;
    if (accept) begin
      mul_a_d = req_a[winner*MUL_SIZE +: MUL_SIZE];
      mul_b_d = req_b[winner*MUL_SIZE +: MUL_SIZE];
    end
  end

  // Shift {accept, winner} down the tag pipe, one stage per cycle.
  always_comb begin
    tag_valid_d    = '0;
    tag_id_d       = '0;
    tag_valid_d[0] = accept;
    tag_id_d[0]    = winner;
    for (int s = 1; s < DEPTH; s++) begin
      tag_valid_d[s] = tag_valid_q[s-1];
      tag_id_d[s]    = tag_id_q[s-1];
    end
  end

  // When a valid tag reaches the last stage, route mul_c to its owner;
  // otherwise drop the strobe and keep the last product on rsp_data.
  always_comb begin
    rsp_valid_d = '0;
    rsp_data_d  = rsp_data_q;
    if (tag_valid_q[DEPTH-1]) begin
      rsp_valid_d[tag_id_q[DEPTH-1]] = 1'b1;
      rsp_data_d                     = mul_c;
    end
  end

  // State update; reset drops every in-flight tag so no stale product is
  // ever delivered after it.
  always_ff @(posedge clk) begin
    if (reset) begin
      ptr_q       <= '0;
      mul_a_q     <= '0;
      mul_b_q     <= '0;
      tag_valid_q <= '0;
      tag_id_q    <= '0;
      rsp_valid_q <= '0;
      rsp_data_q  <= '0;
    end else begin
      ptr_q       <= ptr_d;
      mul_a_q     <= mul_a_d;
      mul_b_q     <= mul_b_d;
      tag_valid_q <= tag_valid_d;
      tag_id_q    <= tag_id_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_data_q  <= rsp_data_d;
    end
  end

  assign mul_a     = mul_a_q;
  assign mul_b     = mul_b_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_data  = rsp_data_q;
  assign busy      = |tag_valid_q;

`ifdef MUL_RR_ARBITER_PERF_EN
  // Per-requester accept counters, element r sits at perf_cnt[r*16 +: 16].
  logic [NUM_REQ-1:0][15:0] perf_cnt_q, perf_cnt_d;

  // Count the winner's accept, sticking at 0xFFFF instead of wrapping.
  always_comb begin
    perf_cnt_d = perf_cnt_q;
    if (accept && (perf_cnt_q[winner] != 16'hFFFF)) begin
      perf_cnt_d[winner] = perf_cnt_q[winner] + 16'd1;
    end
  end

  // Counter registers, cleared together with the rest of the block.
  always_ff @(posedge clk) begin
    if (reset) begin
      perf_cnt_q <= '0;
    end else begin
      perf_cnt_q <= perf_cnt_d;
    end
  end

  assign perf_cnt = perf_cnt_q;
`else
  // Without the performance option no counters are built.
`endif

endmodule

// File: doc/mul_rr_arbiter.md
# mul_rr_arbiter

Round-robin arbiter that shares one pipelined signed (Baugh-Wooley) multiplier among `NUM_REQ` requesters. It accepts at most one operand pair per cycle and drives the registered multiplier operands. It tracks the requester ID of each in-flight operation through the multiplier latency and returns each product to the issuing requester. It sits between DSP client blocks and the single multiplier instance, and sustains one product per cycle.

## Interface
Parameters:
- `MUL_SIZE`, 32: operand width; product width is 2*MUL_SIZE.
- `NUM_REQ`, 4: number of requesters, 2..8.
- `MUL_LAT`, 2: cycles from `mul_a`/`mul_b` valid to the product on `mul_c` (input register + output register).

Ports:
- `clk`  in  1  single clock; all logic on rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `req_valid`  in  NUM_REQ  per-requester request.
- `req_a`  in  NUM_REQ*MUL_SIZE  packed two's-complement operand A; requester r at bits [r*MUL_SIZE +: MUL_SIZE].
- `req_b`  in  NUM_REQ*MUL_SIZE  packed operand B, same packing.
- `req_ready`  out  NUM_REQ  one-hot-or-zero grant; accept = `req_valid[r] & req_ready[r]`.
- `mul_a`, `mul_b`  out  MUL_SIZE  registered operands to the multiplier.
- `mul_c`  in  2*MUL_SIZE  product from the multiplier.
- `rsp_valid`  out  NUM_REQ  one-hot-or-zero result strobe, registered.
- `rsp_data`  out  2*MUL_SIZE  registered product, shared by all requesters.
- `busy`  out  1  high when any operation is in flight.

## Operation
- Arbitration:
  - Round-robin pointer `ptr`, reset 0. Search order is ptr, ptr+1, … mod NUM_REQ.
  - The first valid requester in that order wins.
  - `req_ready` is a combinational function of `req_valid` and `ptr`.
  - Exactly one bit of `req_ready` is high if any `req_valid` is high; otherwise all bits are low.
  - On accept, `ptr` ← winner+1 mod NUM_REQ, wrapping at NUM_REQ-1 → 0. With no accept, `ptr` holds.
- A requester must hold `req_valid`, `req_a` and `req_b` stable until accepted. No back-pressure exists on responses; requesters always sink `rsp_valid`.
- Issue: on accept, the winner's operands are registered into `mul_a`/`mul_b`. With no accept, `mul_a`/`mul_b` hold their previous value; the product is discarded via tag.
- Tag pipe:
  - A shift register of depth 1+MUL_LAT, each entry {valid, id[clog2(NUM_REQ)-1:0]}.
  - Stage 0 loads {accept, winner}.
  - At the last stage, if valid, `rsp_data` ← `mul_c` and `rsp_valid` ← onehot(id); otherwise `rsp_valid` ← 0 and `rsp_data` holds.
- `busy` = OR of all tag-pipe valid bits.
- Arithmetic: the block passes operands and product through unchanged; signedness is the multiplier's (two's complement in, 2*MUL_SIZE two's complement out).
- Reset values: `ptr`=0, tag pipe cleared, `mul_a`=`mul_b`=0, `rsp_valid`=0, `rsp_data`=0, `busy`=0.
- Reset mid-operation: every in-flight tag is dropped. No `rsp_valid` appears for operations accepted before reset, even if `mul_c` still carries their products. `req_ready` is all-zero while `reset` is high.

## Timing
- Accept in cycle t:
  - `mul_a`/`mul_b` valid in t+1.
  - Product on `mul_c` in t+1+MUL_LAT.
  - `rsp_valid`/`rsp_data` valid in t+2+MUL_LAT, i.e. t+4 at the default.
- Throughput: one accept per cycle. Back-to-back accepts from different requesters produce back-to-back responses in accept order.
- Single requester continuously valid: granted every cycle, since the pointer wraps back to it.
- All requesters continuously valid: grants rotate 0,1,…,NUM_REQ-1,0,…; each requester waits at most NUM_REQ-1 cycles.
- Combinational paths: `req_valid` → `req_ready` only. All other outputs are registered.

## Configuration
- `MUL_RR_ARBITER_PERF_EN`:
  - Defined: adds output `perf_cnt` [NUM_REQ*16-1:0], one 16-bit counter per requester. A counter increments on each accept for its requester, saturates at 0xFFFF, and is cleared by `reset`.
  - Undefined: the port and counters are absent. All other behaviour is identical.

## Test plan
- Reset then a single request:
  - Stimulus: `reset` high 2 cycles; then r0 issues A=0x00000003, B=0xFFFFFFFE.
  - Response: `req_ready`=0001 in the accept cycle; `rsp_valid`=0001 exactly 4 cycles later with `rsp_data`=0xFFFFFFFFFFFFFFFA; no other `rsp_valid`.
- Signed corners, r2, back-to-back:
  - 0xFFFFFFFF×0xFFFFFFFF → 0x0000000000000001.
  - 0x80000000×0x80000000 → 0x4000000000000000.
  - 0x7FFFFFFF×0x80000000 → 0xC000000080000000.
  - All three responses arrive on consecutive cycles in order.
- Fairness: all four requesters valid for 8 cycles → grant sequence 0,1,2,3,0,1,2,3; `rsp_valid` follows the same sequence 4 cycles later.
- Pointer wrap and skip:
  - Stimulus: accept r3, then r1 and r2 valid together.
  - Response: r1 is granted (ptr wrapped to 0, r0 idle), then r2.
- Reset mid-flight:
  - Stimulus: accept on r0 and r1 in consecutive cycles; assert `reset` the next cycle.
  - Response: `rsp_valid` stays 0 for 6 cycles; `busy`=0 the cycle after reset.
- Perf (with `MUL_RR_ARBITER_PERF_EN`): 70000 accepts on r1 → r1's `perf_cnt` field = 0xFFFF; other fields 0.
